// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of a CDC FIFO
//   among N_REQ valid/ready/last word streams in the FIFO write clock domain.
//   A grant covers one packet or at most MAX_BURST words, whichever ends
//   first. Each written word is tagged with the source index in its upper bits.
//
// Ports
//   i_clk          FIFO write clock
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    per-requester word valid
//   i_req_data     requester k word at [k*WIDTH +: WIDTH]
//   i_req_last     per-requester end-of-packet marker
//   o_req_ready    per-requester accept strobe (only the granted bit can be set)
//   o_fifo_wen     FIFO write enable
//   o_fifo_wdata   {grant_id, payload}, zero when not writing
//   i_fifo_full    FIFO full flag
//   o_grant_valid  a requester holds the grant
//   o_grant_id     registered index of the granted requester
//
// State table
//   IDLE  | no grant held; pick the next valid requester after last_id
//   BURST | grant_id owns the write port until last, burst cap or valid drop

module fifo_write_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]       i_req_last,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_fifo_wen,
    output logic [ID_W+WIDTH-1:0]  o_fifo_wdata,
    input  logic                   i_fifo_full,
    output logic                   o_grant_valid,
    output logic [ID_W-1:0]        o_grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   grant_id_q,  grant_id_d;
    logic [ID_W-1:0]   last_id_q,   last_id_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [WIDTH-1:0]  req_data_a [N_REQ];
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   sel_id;
    logic              sel_found;
    logic              gnt_valid;
    logic              gnt_last;
    logic              xfer;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_data_a[k] = i_req_data[k*WIDTH +: WIDTH];
        end
    end

    // Scan from the farthest offset down to last_id+1 so the nearest valid
    // requester after the previous owner is the one left in sel_id.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = ID_W'((int'(last_id_q) + off) % N_REQ);
            if (i_req_valid[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    assign gnt_valid = i_req_valid[grant_id_q];
    assign gnt_last  = i_req_last[grant_id_q];
    assign xfer      = (state_q == BURST) && gnt_valid && !i_fifo_full;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        burst_cnt_d   = burst_cnt_q;
        o_req_ready   = '0;
        o_fifo_wen    = 1'b0;
        o_fifo_wdata  = '0;
        o_grant_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d  = sel_id;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                o_grant_valid = 1'b1;
                if (xfer) begin
                    o_req_ready[grant_id_q] = 1'b1;
                    o_fifo_wen              = 1'b1;
                    o_fifo_wdata            = {grant_id_q, req_data_a[grant_id_q]};
                    burst_cnt_d             = burst_cnt_q + CNT_W'(1);
                    if (gnt_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end else if (!gnt_valid) begin
                    // Requester went away mid-packet: give the port up even if full.
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end
                // Full with valid high: hold grant and count.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign o_grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ready;
    logic        wen;
    logic [9:0]  wdata;
    logic        full;
    logic        gv;
    logic [1:0]  gid;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (valid),
        .i_req_data    (data),
        .i_req_last    (last),
        .o_req_ready   (ready),
        .o_fifo_wen    (wen),
        .o_fifo_wdata  (wdata),
        .i_fifo_full   (full),
        .o_grant_valid (gv),
        .o_grant_id    (gid)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] act;
    assign act = {14'd0, gv, gid, ready, wen, wdata};

    function automatic logic [31:0] pack(logic g, logic [1:0] id, logic [3:0] r, logic w, logic [9:0] d);
        return {14'd0, g, id, r, w, d};
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        f;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic f, logic [31:0] e);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.f = f; t.exp = e;
        return t;
    endfunction

    vec_t tbl_rr [14];
    vec_t tbl_drop [6];

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic f);
        @(negedge clk);
        valid = v; data = d; last = l; full = f;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0; data = '0; last = '0; full = 1'b0;
        #1;
        check("reset_outputs", act, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state
    int m_busy, m_gid, m_last, m_cnt;

    initial begin
        int words;
        logic [12:0] pat;
        logic [8:0]  st_full = 9'b000011100;
        logic [8:0]  st_wen  = 9'b011100010;
        logic [8:0]  st_gv   = 9'b011111110;

        tbl_rr[0]  = mk(4'h0, 32'h0,        4'h0, 0, pack(0, 0, 4'h0, 0, 10'h0));
        tbl_rr[1]  = mk(4'h4, 32'h00A50000, 4'h4, 0, pack(0, 0, 4'h0, 0, 10'h0));
        tbl_rr[2]  = mk(4'h4, 32'h00A50000, 4'h4, 0, pack(1, 2, 4'h4, 1, 10'h2A5));
        tbl_rr[3]  = mk(4'h0, 32'h0,        4'h0, 0, pack(0, 2, 4'h0, 0, 10'h0));
        tbl_rr[4]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(0, 2, 4'h0, 0, 10'h0));
        tbl_rr[5]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(1, 3, 4'h8, 1, 10'h313));
        tbl_rr[6]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(0, 3, 4'h0, 0, 10'h0));
        tbl_rr[7]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(1, 0, 4'h1, 1, 10'h010));
        tbl_rr[8]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(0, 0, 4'h0, 0, 10'h0));
        tbl_rr[9]  = mk(4'hF, 32'h13121110, 4'hF, 0, pack(1, 1, 4'h2, 1, 10'h111));
        tbl_rr[10] = mk(4'hF, 32'h13121110, 4'hF, 0, pack(0, 1, 4'h0, 0, 10'h0));
        tbl_rr[11] = mk(4'hF, 32'h13121110, 4'hF, 1, pack(1, 2, 4'h0, 0, 10'h0));
        tbl_rr[12] = mk(4'hF, 32'h13121110, 4'hF, 0, pack(1, 2, 4'h4, 1, 10'h212));
        tbl_rr[13] = mk(4'h0, 32'h0,        4'h0, 0, pack(0, 2, 4'h0, 0, 10'h0));

        tbl_drop[0] = mk(4'h8, 32'h41000000, 4'h0, 0, pack(0, 0, 4'h0, 0, 10'h0));
        tbl_drop[1] = mk(4'h8, 32'h41000000, 4'h0, 0, pack(1, 3, 4'h8, 1, 10'h341));
        tbl_drop[2] = mk(4'h8, 32'h42000000, 4'h0, 0, pack(1, 3, 4'h8, 1, 10'h342));
        tbl_drop[3] = mk(4'h6, 32'h00002000, 4'h0, 0, pack(1, 3, 4'h0, 0, 10'h0));
        tbl_drop[4] = mk(4'h6, 32'h00002000, 4'h0, 0, pack(0, 3, 4'h0, 0, 10'h0));
        tbl_drop[5] = mk(4'h6, 32'h00002000, 4'h0, 0, pack(1, 1, 4'h2, 1, 10'h120));

        // Single word, round robin, one-cycle full stall
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl_rr[i].v, tbl_rr[i].d, tbl_rr[i].l, tbl_rr[i].f);
            check($sformatf("rr_vec%0d", i), act, tbl_rr[i].exp);
        end

        // Valid drop mid-packet
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl_drop[i].v, tbl_drop[i].d, tbl_drop[i].l, tbl_drop[i].f);
            check($sformatf("drop_vec%0d", i), act, tbl_drop[i].exp);
        end

        // Burst cap: 10 words from requester 0 -> 4, 4, 2 with idle gaps
        do_reset();
        words = 0;
        pat = '0;
        for (int c = 0; c < 13; c++) begin
            step((words < 10) ? 4'h1 : 4'h0, 32'(words), 4'h0, 1'b0);
            pat[c] = wen;
            if (wen) begin
                check("cap_word", {22'd0, wdata}, 32'(words));
                words++;
            end
        end
        check("cap_pattern", {19'd0, pat}, {19'd0, 13'b1101111011110});

        // Full stall during requester 1 burst
        do_reset();
        words = 0;
        for (int c = 0; c < 9; c++) begin
            step((words < 4) ? 4'h2 : 4'h0, 32'(words) << 8, 4'h0, st_full[c]);
            check($sformatf("stall_c%0d", c), {26'd0, gv, ready, wen},
                  {26'd0, st_gv[c], st_wen[c] ? 4'h2 : 4'h0, st_wen[c]});
            if (wen) begin
                check("stall_word", {22'd0, wdata}, 32'h100 + 32'(words));
                words++;
            end
        end

        // Async reset mid-burst
        do_reset();
        step(4'h4, 32'h00770000, 4'h0, 1'b0);
        step(4'h4, 32'h00770000, 4'h0, 1'b0);
        check("areset_pre", act, pack(1, 2, 4'h4, 1, 10'h277));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_mid", act, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 4'hF; last = 4'hF; data = 32'h13121110; full = 1'b0;
        #1;
        check("areset_idle", act, 32'd0);
        @(negedge clk);
        #1;
        check("areset_prio", act, pack(1, 0, 4'h1, 1, 10'h010));

        // Randomised run against the reference model
        do_reset();
        m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  rv, rl;
            logic [31:0] e;
            int          dv;
            for (int k = 0; k < N; k++) begin
                rv[k] = ($urandom_range(0, 9) < 7);
                rl[k] = ($urandom_range(0, 9) < 3);
            end
            step(rv, $urandom, rl, ($urandom_range(0, 4) == 0));
            if (m_busy == 0) begin
                e = pack(0, 2'(m_gid), 4'h0, 0, 10'h0);
                for (int k = 1; k <= N; k++) begin
                    if (valid[(m_last + k) % N]) begin
                        m_gid  = (m_last + k) % N;
                        m_busy = 1;
                        m_cnt  = 0;
                        break;
                    end
                end
            end else begin
                dv = int'(data[m_gid*W +: W]);
                if (valid[m_gid] && !full) begin
                    e = pack(1, 2'(m_gid), 4'(1 << m_gid), 1, 10'(m_gid * 256 + dv));
                    m_cnt++;
                    if (last[m_gid] || m_cnt == MB) begin
                        m_busy = 0;
                        m_last = m_gid;
                    end
                end else begin
                    e = pack(1, 2'(m_gid), 4'h0, 0, 10'h0);
                    if (!valid[m_gid]) begin
                        m_busy = 0;
                        m_last = m_gid;
                    end
                end
            end
            check($sformatf("rand_c%0d", c), act, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing the single write port of one clock-domain-crossing FIFO among `N_REQ` requesters in the write clock domain. Each requester presents a valid/ready/last word stream. The arbiter grants one requester at a time for a burst of up to `MAX_BURST` words. It drives the FIFO write enable and data, prefixes each word with the source ID, and honours the FIFO full flag.

## Interface

- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: payload width per word.
- `MAX_BURST`, 4: maximum words per grant, ≥1.
- Derived: `ID_W` = max(1, $clog2(`N_REQ`)); `CNT_W` = $clog2(`MAX_BURST`+1).

Ports:

- `i_clk`  in  1  single clock, the FIFO write clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_req_valid`  in  `N_REQ`  bit k: requester k has a word.
- `i_req_data`  in  `N_REQ`*`WIDTH`  requester k's word at [k*`WIDTH` +: `WIDTH`].
- `i_req_last`  in  `N_REQ`  bit k: requester k's current word ends its packet.
- `o_req_ready`  out  `N_REQ`  bit k: requester k's word is accepted this cycle.
- `o_fifo_wen`  out  1  FIFO write enable.
- `o_fifo_wdata`  out  `ID_W`+`WIDTH`  {grant_id, payload}.
- `i_fifo_full`  in  1  FIFO full flag.
- `o_grant_valid`  out  1  a requester currently holds the grant.
- `o_grant_id`  out  `ID_W`  index of the granted requester.

## Operation

**States**

- FSM states are IDLE and BURST.
- Registers: `state`, `grant_id`, `last_id`, `burst_cnt` (`CNT_W` bits).

**IDLE**

- `o_grant_valid`=0 and all `o_req_ready`=0.
- If any `i_req_valid` is set: select the first set bit scanning `last_id`+1, `last_id`+2, … modulo `N_REQ`.
- Register the selection into `grant_id`, clear `burst_cnt`, and go to BURST.
- Otherwise stay in IDLE.

**BURST**

- `o_grant_valid`=1.
- `o_req_ready[grant_id]` = `i_req_valid[grant_id]` & ~`i_fifo_full`; all other ready bits are 0.
- A transfer is valid & ready on the granted requester.
- On a transfer: `o_fifo_wen`=1, `o_fifo_wdata`={`grant_id`, data[`grant_id`]}, and `burst_cnt` increments.
- Release goes to IDLE with `last_id` <= `grant_id`. The first matching condition, checked in this order, causes release:
  1. A transfer with `i_req_last[grant_id]`=1.
  2. A transfer making `burst_cnt`+1 == `MAX_BURST`.
  3. `i_req_valid[grant_id]`=0, regardless of `i_fifo_full`.
- `i_fifo_full`=1 with valid=1 holds the grant: no transfer, `burst_cnt` unchanged, no release.

**Outputs and reset**

- `o_fifo_wen`, `o_req_ready` and `o_fifo_wdata` are combinational from registered state and the inputs. `o_fifo_wdata` is all-zero whenever `o_fifo_wen`=0.
- Non-granted requesters' valid, data and last inputs are ignored during BURST.
- `o_fifo_wen` is never 1 while `i_fifo_full`=1.
- Reset (`i_rst_n`=0, asynchronous) sets `state`=IDLE, `grant_id`=0, `last_id`=`N_REQ`-1, `burst_cnt`=0.
  - After reset, requester 0 has top priority.
  - Resulting outputs: `o_grant_valid`=0, `o_grant_id`=0, `o_fifo_wen`=0, `o_req_ready`=0, `o_fifo_wdata`=0.
- Reset asserted mid-burst drops `o_fifo_wen` and `o_req_ready` immediately, without waiting for a clock edge. A partially written packet stays in the FIFO; the consumer must tolerate it.

## Timing

- Arbitration latency: valid seen in IDLE at edge N means `o_grant_valid`=1 and the first possible write in cycle N+1.
- Writes within a burst are back-to-back, one word per cycle, while not full.
- Every release costs one IDLE cycle. Peak throughput for a single active requester is `MAX_BURST`/(`MAX_BURST`+1).
- Fairness: a continuously valid requester waits at most (`N_REQ`-1) × (`MAX_BURST`+1) cycles plus FIFO-full stall cycles.
- `o_grant_id` is registered; it changes only on the edge entering BURST and holds through IDLE.

## Test plan

- **Reset/single word:** reset, then valid[2]=1 with last=1 and data 0xA5 → one cycle of `o_fifo_wen`=1 with wdata={2'd2, 8'hA5}; next cycle IDLE; `last_id`=2.
- **Burst cap:** requester 0 streams 10 words with last=0 (`MAX_BURST`=4) → writes 4, 4, 2, each group separated by one IDLE cycle, and the grant returns to 0 each time because no other requester is valid.
- **Round robin:** all four valid continuously with single-word packets after reset → grant order 0,1,2,3,0,…; each write is followed by one idle cycle.
- **Full stall:** hold `i_fifo_full`=1 for 3 cycles during requester 1's burst → `o_fifo_wen`=0 and ready[1]=0 for those 3 cycles; the grant is held and `burst_cnt` is frozen; the burst resumes with the remaining words.
- **Valid drop:** requester 3 deasserts valid after 2 of 4 words with no last → release, and the next grant goes to the next valid requester after index 3.
- **Async reset mid-burst:** pull `i_rst_n` low between clock edges during BURST → `o_fifo_wen`, `o_req_ready` and `o_grant_valid` go to 0 before the next edge; after release, requester 0 has priority.
